// File: rtl/arch_mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   state_e  : arbiter FSM states
//   owner_e  : which requester owns the access in flight (fetch or data)
//   MEM_LAT_DEF / MAX_LAT : default and largest supported memory latency
//   LAT_CW   : width of the latency down-counter
//   is_misaligned() : word-alignment test on the two address LSBs
package arch_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int MEM_LAT_DEF = 1;
    localparam int MAX_LAT     = 4;
    localparam int LAT_CW      = $clog2(MAX_LAT + 1);

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter used to time the WAIT phase of an access.
//   clk        : clock
//   reset      : asynchronous active-low reset (count -> 0)
//   i_load     : load i_load_val on the next rising edge
//   i_load_val : value to load
//   o_done     : high while the count is zero
module mem_lat_counter
    import arch_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [LAT_CW-1:0] i_load_val,
    output logic              o_done
);

    logic [LAT_CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of one shared
// unified-memory port. One access at a time: IDLE -> ACCESS -> [WAIT] -> RESP.
//   clk, reset                        : clock, async active-low reset
//   i_req, i_addr                     : fetch request / read address
//   i_gnt, i_rvalid, i_err, i_rdata   : fetch grant, completion, misalign flag, data
//   d_req, d_we, d_addr, d_wdata      : data request, write enable, address, write data
//   d_gnt, d_rvalid, d_err, d_rdata   : data grant, completion, misalign flag, data
//   m_en, m_we, m_addr, m_wdata       : shared memory port
//   m_rdata                           : memory read data, valid MEM_LAT cycles after m_en
//   busy                              : high whenever the FSM is not IDLE
// MEM_LAT must be in 1..MAX_LAT.
module mem_arbiter
    import arch_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic          i_err,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    // With MEM_LAT=1 the word is ready at the end of ACCESS, so WAIT is skipped.
    localparam logic LAT_ONE = (MEM_LAT == 1);
    // The counter is loaded while in ACCESS and reaches zero in the last WAIT
    // cycle, so WAIT lasts MEM_LAT-1 cycles.
    localparam logic [LAT_CW-1:0] WAIT_LOAD = (MEM_LAT > 1) ? LAT_CW'(MEM_LAT - 2) : '0;

    state_e        r_state;
    owner_e        r_own;
    owner_e        r_last;
    logic          r_we;
    logic          r_mis;
    logic          r_i_gnt;
    logic          r_d_gnt;
    logic          r_i_rvalid;
    logic          r_d_rvalid;
    logic          r_i_err;
    logic          r_d_err;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic          r_busy;

    logic          w_pick_d;
    logic          w_any;
    logic [AW-1:0] w_sel_addr;
    logic          w_sel_we;
    logic          w_sel_mis;
    logic          w_cnt_load;
    logic          w_cnt_done;
    logic          w_resp_now;

    mem_lat_counter u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (WAIT_LOAD),
        .o_done     (w_cnt_done)
    );

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_pick_d = d_req;
        if (i_req && d_req) begin
            w_pick_d = (r_last == OWN_I);
        end
    end

    assign w_any      = i_req | d_req;
    assign w_sel_addr = w_pick_d ? d_addr : i_addr;
    assign w_sel_we   = w_pick_d & d_we;
    assign w_sel_mis  = is_misaligned(w_sel_addr[1:0]);
    assign w_cnt_load = (r_state == ST_ACCESS);

    // The edge that enters RESP is the one MEM_LAT cycles after the m_en cycle,
    // which is where m_rdata is sampled.
    assign w_resp_now = ((r_state == ST_ACCESS) && LAT_ONE) ||
                        ((r_state == ST_WAIT) && w_cnt_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_own      <= OWN_I;
            r_last     <= OWN_D;
            r_we       <= 1'b0;
            r_mis      <= 1'b0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_busy     <= 1'b0;
        end else begin
            // Single-cycle pulses default low; each state raises what it needs.
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_ACCESS;
                        r_busy   <= 1'b1;
                        r_own    <= w_pick_d ? OWN_D : OWN_I;
                        r_last   <= w_pick_d ? OWN_D : OWN_I;
                        r_we     <= w_sel_we;
                        r_mis    <= w_sel_mis;
                        r_i_gnt  <= ~w_pick_d;
                        r_d_gnt  <= w_pick_d;
                        // A misaligned access is granted but never reaches memory.
                        r_m_en   <= ~w_sel_mis;
                        r_m_we   <= w_sel_we & ~w_sel_mis;
                        r_m_addr <= w_sel_addr;
                        if (w_pick_d) begin
                            r_m_wdata <= d_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state <= LAT_ONE ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_resp_now) begin
                if (r_own == OWN_I) begin
                    r_i_rvalid <= 1'b1;
                    r_i_err    <= r_mis;
                    if (!r_mis) begin
                        r_i_rdata <= m_rdata;
                    end
                end else begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= r_mis;
                    // Writes only acknowledge; d_rdata keeps the last read word.
                    if (!r_mis && !r_we) begin
                        r_d_rdata <= m_rdata;
                    end
                end
            end
        end
    end

    assign i_gnt    = r_i_gnt;
    assign i_rvalid = r_i_rvalid;
    assign i_err    = r_i_err;
    assign i_rdata  = r_i_rdata;
    assign d_gnt    = r_d_gnt;
    assign d_rvalid = r_d_rvalid;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign busy     = r_busy;

endmodule
